rv_iommu_ls_arb: RTL and testbench

- Shares the single IOMMU memory load/store port between N_REQ requesters: page-table walker, command-queue fetch, fault/page-request queue writer.
- Round-robin arbitrates requests and registers the winner onto the downstream port.
- Appends the requester index to the downstream tag and routes load/AMO responses back by that index.
- Per-requester outstanding-response counters provide back-pressure.

---
 rtl/rv_iommu_ls_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_rv_iommu_ls_arb.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_iommu_ls_arb.sv
// Round-robin arbiter sharing the IOMMU memory load/store port between N_REQ requesters.
// Downstream tags carry the requester index so load/AMO responses route back to their owner.
module rv_iommu_ls_arb #(
    parameter int N_REQ   = 3,
    parameter int TAG_W   = 4,
    parameter int MAX_OUT = 4,
    localparam int IW     = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ*46-1:0]   r_addr_i,
    input  logic [N_REQ*2-1:0]    r_op_i,
    input  logic [N_REQ*TAG_W-1:0] r_tag_i,
    input  logic [N_REQ*7-1:0]    r_size_i,
    input  logic [N_REQ-1:0]      r_req_irdy_i,
    output logic [N_REQ-1:0]      r_req_trdy_o,
    output logic [511:0]          r_ld_data_o,
    output logic                  r_ld_acc_fault_o,
    output logic                  r_ld_poison_o,
    output logic [TAG_W-1:0]      r_ld_tag_o,
    output logic [N_REQ-1:0]      r_ld_irdy_o,
    input  logic [N_REQ-1:0]      r_ld_trdy_i,
    output logic [45:0]           m_addr_o,
    output logic [1:0]            m_op_o,
    output logic [IW+TAG_W-1:0]   m_tag_o,
    output logic [6:0]            m_size_o,
    output logic                  m_req_irdy_o,
    input  logic                  m_req_trdy_i,
    input  logic [511:0]          m_ld_data_i,
    input  logic                  m_ld_acc_fault_i,
    input  logic                  m_ld_poison_i,
    input  logic [IW+TAG_W-1:0]   m_ld_tag_i,
    input  logic                  m_ld_irdy_i,
    output logic                  m_ld_trdy_o,
    output logic                  spur_rsp_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [45:0]          m_addr_q, m_addr_d;
    logic [1:0]           m_op_q, m_op_d;
    logic [IW+TAG_W-1:0]  m_tag_q, m_tag_d;
    logic [6:0]           m_size_q, m_size_d;
    logic                 m_req_irdy_q, m_req_irdy_d;
    logic [3:0]           cnt_q [N_REQ];
    logic [3:0]           cnt_d [N_REQ];
    logic                 buf_full_q, buf_full_d;
    logic [511:0]         buf_data_q, buf_data_d;
    logic                 buf_fault_q, buf_fault_d;
    logic                 buf_poison_q, buf_poison_d;
    logic [TAG_W-1:0]     buf_tag_q, buf_tag_d;
    logic [IW-1:0]        buf_idx_q, buf_idx_d;
    logic                 spur_q, spur_d;

    logic [N_REQ-1:0]     elig_s, inc_s, dec_s;
    logic                 found_s, take_s, accept_s;
    logic [IW-1:0]        gnt_s, cur_g_s;
    logic [IW:0]          cand_s;
    logic                 deliver_s, m_ld_trdy_s, m_ld_hs_s;
    logic [IW-1:0]        rsp_idx_s, rsp_sel_s;
    logic                 rsp_idx_ok_s, rsp_none_s, rsp_good_s;

    // A STORE (op bit 0 set) never returns a response, so it ignores the credit limit.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            elig_s[k] = r_req_irdy_i[k] & (r_op_i[2*k] | (cnt_q[k] < 4'(MAX_OUT)));
        end
    end

    // First eligible requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        take_s  = 1'b0;
        gnt_s   = '0;
        cand_s  = '0;
        for (int o = 0; o < N_REQ; o++) begin
            cand_s  = {1'b0, rr_q} + (IW+1)'(o);
            cand_s  = (cand_s >= (IW+1)'(N_REQ)) ? cand_s - (IW+1)'(N_REQ) : cand_s;
            take_s  = ~found_s & elig_s[cand_s[IW-1:0]];
            gnt_s   = take_s ? cand_s[IW-1:0] : gnt_s;
            found_s = found_s | take_s;
        end
    end

    assign accept_s = ~rst & (state_q == ST_IDLE) & found_s;
    assign cur_g_s  = m_tag_q[IW+TAG_W-1 -: IW];

    // Request FSM: capture the winner in IDLE, hold the downstream request in BUSY.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        m_addr_d     = m_addr_q;
        m_op_d       = m_op_q;
        m_tag_d      = m_tag_q;
        m_size_d     = m_size_q;
        m_req_irdy_d = m_req_irdy_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    m_addr_d     = r_addr_i[46*int'(gnt_s) +: 46];
                    m_op_d       = r_op_i[2*int'(gnt_s) +: 2];
                    m_tag_d      = {gnt_s, r_tag_i[TAG_W*int'(gnt_s) +: TAG_W]};
                    m_size_d     = r_size_i[7*int'(gnt_s) +: 7];
                    m_req_irdy_d = 1'b1;
                    state_d      = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (m_req_trdy_i) begin
                    m_req_irdy_d = 1'b0;
                    rr_d         = (cur_g_s == IW'(N_REQ-1)) ? '0 : cur_g_s + IW'(1);
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                m_req_irdy_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    assign deliver_s    = buf_full_q & r_ld_trdy_i[buf_idx_q];
    assign m_ld_trdy_s  = ~rst & (~buf_full_q | deliver_s);
    assign m_ld_hs_s    = m_ld_irdy_i & m_ld_trdy_s;
    assign rsp_idx_s    = m_ld_tag_i[IW+TAG_W-1 -: IW];
    assign rsp_idx_ok_s = ({1'b0, rsp_idx_s} < (IW+1)'(N_REQ));
    assign rsp_sel_s    = rsp_idx_ok_s ? rsp_idx_s : '0;
    // The counter includes a response still parked in the buffer; that one is not awaited.
    assign rsp_none_s   = (cnt_q[rsp_sel_s] ==
                           ((buf_full_q && (buf_idx_q == rsp_sel_s)) ? 4'd1 : 4'd0));
    assign rsp_good_s   = m_ld_hs_s & rsp_idx_ok_s & ~rsp_none_s;
    assign spur_d       = m_ld_hs_s & ~rsp_good_s;

    // One-entry response buffer: a fresh response may replace the one being delivered.
    always_comb begin
        buf_full_d   = buf_full_q;
        buf_data_d   = buf_data_q;
        buf_fault_d  = buf_fault_q;
        buf_poison_d = buf_poison_q;
        buf_tag_d    = buf_tag_q;
        buf_idx_d    = buf_idx_q;
        if (rsp_good_s) begin
            buf_full_d   = 1'b1;
            buf_data_d   = m_ld_data_i;
            buf_fault_d  = m_ld_acc_fault_i;
            buf_poison_d = m_ld_poison_i;
            buf_tag_d    = m_ld_tag_i[TAG_W-1:0];
            buf_idx_d    = rsp_idx_s;
        end else if (deliver_s) begin
            buf_full_d = 1'b0;
        end else begin
            buf_full_d = buf_full_q;
        end
    end

    // Outstanding load/AMO credits per requester.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            inc_s[k] = accept_s & (gnt_s == IW'(k)) & ~r_op_i[2*k];
            dec_s[k] = deliver_s & (buf_idx_q == IW'(k));
            cnt_d[k] = cnt_q[k] + {3'b000, inc_s[k]} - {3'b000, dec_s[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            m_addr_q     <= '0;
            m_op_q       <= '0;
            m_tag_q      <= '0;
            m_size_q     <= '0;
            m_req_irdy_q <= 1'b0;
            buf_full_q   <= 1'b0;
            buf_data_q   <= '0;
            buf_fault_q  <= 1'b0;
            buf_poison_q <= 1'b0;
            buf_tag_q    <= '0;
            buf_idx_q    <= '0;
            spur_q       <= 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                cnt_q[k] <= 4'd0;
            end
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            m_addr_q     <= m_addr_d;
            m_op_q       <= m_op_d;
            m_tag_q      <= m_tag_d;
            m_size_q     <= m_size_d;
            m_req_irdy_q <= m_req_irdy_d;
            buf_full_q   <= buf_full_d;
            buf_data_q   <= buf_data_d;
            buf_fault_q  <= buf_fault_d;
            buf_poison_q <= buf_poison_d;
            buf_tag_q    <= buf_tag_d;
            buf_idx_q    <= buf_idx_d;
            spur_q       <= spur_d;
            for (int k = 0; k < N_REQ; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign r_req_trdy_o     = accept_s ? (ONE_HOT0 << gnt_s) : '0;
    assign m_addr_o         = m_addr_q;
    assign m_op_o           = m_op_q;
    assign m_tag_o          = m_tag_q;
    assign m_size_o         = m_size_q;
    assign m_req_irdy_o     = m_req_irdy_q;
    assign m_ld_trdy_o      = m_ld_trdy_s;
    assign r_ld_irdy_o      = buf_full_q ? (ONE_HOT0 << buf_idx_q) : '0;
    assign r_ld_data_o      = buf_data_q;
    assign r_ld_acc_fault_o = buf_fault_q;
    assign r_ld_poison_o    = buf_poison_q;
    assign r_ld_tag_o       = buf_tag_q;
    assign spur_rsp_o       = spur_q;

endmodule

// File: tb/tb_rv_iommu_ls_arb.sv
// Directed bench for rv_iommu_ls_arb: a transaction-level model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_rv_iommu_ls_arb;
    localparam int N  = 3;
    localparam int TW = 4;
    localparam int MO = 4;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N*46-1:0]     r_addr_i;
    logic [N*2-1:0]      r_op_i;
    logic [N*TW-1:0]     r_tag_i;
    logic [N*7-1:0]      r_size_i;
    logic [N-1:0]        r_req_irdy_i, r_req_trdy_o, r_ld_irdy_o, r_ld_trdy_i;
    logic [511:0]        r_ld_data_o, m_ld_data_i;
    logic                r_ld_acc_fault_o, r_ld_poison_o;
    logic [TW-1:0]       r_ld_tag_o;
    logic [45:0]         m_addr_o;
    logic [1:0]          m_op_o;
    logic [IW+TW-1:0]    m_tag_o, m_ld_tag_i;
    logic [6:0]          m_size_o;
    logic                m_req_irdy_o, m_req_trdy_i;
    logic                m_ld_acc_fault_i, m_ld_poison_i, m_ld_irdy_i, m_ld_trdy_o, spur_rsp_o;

    rv_iommu_ls_arb #(.N_REQ(N), .TAG_W(TW), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst),
        .r_addr_i(r_addr_i), .r_op_i(r_op_i), .r_tag_i(r_tag_i), .r_size_i(r_size_i),
        .r_req_irdy_i(r_req_irdy_i), .r_req_trdy_o(r_req_trdy_o),
        .r_ld_data_o(r_ld_data_o), .r_ld_acc_fault_o(r_ld_acc_fault_o),
        .r_ld_poison_o(r_ld_poison_o), .r_ld_tag_o(r_ld_tag_o),
        .r_ld_irdy_o(r_ld_irdy_o), .r_ld_trdy_i(r_ld_trdy_i),
        .m_addr_o(m_addr_o), .m_op_o(m_op_o), .m_tag_o(m_tag_o), .m_size_o(m_size_o),
        .m_req_irdy_o(m_req_irdy_o), .m_req_trdy_i(m_req_trdy_i),
        .m_ld_data_i(m_ld_data_i), .m_ld_acc_fault_i(m_ld_acc_fault_i),
        .m_ld_poison_i(m_ld_poison_i), .m_ld_tag_i(m_ld_tag_i),
        .m_ld_irdy_i(m_ld_irdy_i), .m_ld_trdy_o(m_ld_trdy_o), .spur_rsp_o(spur_rsp_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int gq[$];
    int gt[$];
    int spur_cnt = 0;
    int rld_cnt = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model: an issued request is owed a response until that response enters the buffer.
    bit           model_on = 1'b0;
    bit           md_busy = 1'b0;
    int           md_ptr = 0;
    int           md_g = 0;
    logic [45:0]  md_a;
    logic [1:0]   md_o;
    logic [TW-1:0] md_t;
    logic [6:0]   md_s;
    int           owed [N];
    bit           bf_full = 1'b0;
    int           bf_idx = 0;
    logic [511:0] bf_data;
    logic         bf_fault, bf_poison;
    logic [TW-1:0] bf_tag;
    bit           spur_pend = 1'b0;

    always @(negedge clk) begin
        int win, k, idx, held;
        logic [N-1:0] exp_trdy, exp_ld;
        logic exp_mtrdy, spur_n;
        if (rst) begin
            model_on = 1'b1; md_busy = 1'b0; md_ptr = 0; bf_full = 1'b0; spur_pend = 1'b0;
            for (int i = 0; i < N; i++) owed[i] = 0;
        end else if (model_on) begin
            win = -1;
            for (int o = 0; o < N; o++) begin
                k = (md_ptr + o) % N;
                held = (bf_full && bf_idx == k) ? 1 : 0;
                if (win < 0 && r_req_irdy_i[k] && (r_op_i[2*k] || (owed[k] + held) < MO)) win = k;
            end
            exp_trdy = (!md_busy && win >= 0) ? (N'(1) << win) : '0;
            chk("req_trdy", r_req_trdy_o, exp_trdy);
            chk("m_req_irdy", m_req_irdy_o, md_busy);
            if (md_busy) begin
                chk("m_addr", m_addr_o, md_a);
                chk("m_op", m_op_o, md_o);
                chk("m_tag", m_tag_o, {2'(md_g), md_t});
                chk("m_size", m_size_o, md_s);
            end
            exp_mtrdy = !bf_full || r_ld_trdy_i[bf_idx];
            chk("m_ld_trdy", m_ld_trdy_o, exp_mtrdy);
            exp_ld = bf_full ? (N'(1) << bf_idx) : '0;
            chk("r_ld_irdy", r_ld_irdy_o, exp_ld);
            if (bf_full) begin
                chk("r_ld_data", r_ld_data_o, bf_data);
                chk("r_ld_tag", r_ld_tag_o, bf_tag);
                chk("r_ld_fault", r_ld_acc_fault_o, bf_fault);
                chk("r_ld_poison", r_ld_poison_o, bf_poison);
            end
            chk("spur", spur_rsp_o, spur_pend);
            spur_n = 1'b0;
            if (bf_full && r_ld_trdy_i[bf_idx]) bf_full = 1'b0;
            if (m_ld_irdy_i && exp_mtrdy) begin
                idx = int'(m_ld_tag_i[IW+TW-1:TW]);
                if (idx >= N) spur_n = 1'b1;
                else if (owed[idx] == 0) spur_n = 1'b1;
                else begin
                    owed[idx]--; bf_full = 1'b1; bf_idx = idx; bf_data = m_ld_data_i;
                    bf_fault = m_ld_acc_fault_i; bf_poison = m_ld_poison_i;
                    bf_tag = m_ld_tag_i[TW-1:0];
                end
            end
            if (!md_busy && win >= 0) begin
                md_busy = 1'b1; md_g = win;
                md_a = r_addr_i[46*win +: 46]; md_o = r_op_i[2*win +: 2];
                md_t = r_tag_i[TW*win +: TW]; md_s = r_size_i[7*win +: 7];
                if (!r_op_i[2*win]) owed[win]++;
            end else if (md_busy && m_req_trdy_i) begin
                md_busy = 1'b0; md_ptr = (md_g + 1) % N;
            end
            spur_pend = spur_n;
        end
    end

    // Event log of what the DUT actually did, for the scenario-level expectations.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (r_req_trdy_o[i]) begin gq.push_back(i); gt.push_back(cyc); end
            end
            if (spur_rsp_o) spur_cnt++;
            if (r_ld_irdy_o != '0) rld_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_req(input int k, input logic [1:0] op, input logic [45:0] a,
                           input logic [TW-1:0] t, input logic [6:0] s);
        r_addr_i[46*k +: 46] = a; r_op_i[2*k +: 2] = op;
        r_tag_i[TW*k +: TW] = t;  r_size_i[7*k +: 7] = s;
        r_req_irdy_i[k] = 1'b1;
    endtask

    task automatic wait_accept(input int k);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (r_req_trdy_o[k]) got = 1'b1;
        end
        @(posedge clk); #1;
        r_req_irdy_i[k] = 1'b0;
        chk($sformatf("accept_req%0d", k), got, 1'b1);
    endtask

    task automatic send_rsp(input logic [IW+TW-1:0] t, input logic [511:0] d,
                            input logic f, input logic p);
        bit got = 1'b0;
        m_ld_tag_i = t; m_ld_data_i = d; m_ld_acc_fault_i = f; m_ld_poison_i = p;
        m_ld_irdy_i = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m_ld_trdy_o) got = 1'b1;
        end
        @(posedge clk); #1;
        m_ld_irdy_i = 1'b0;
        chk("rsp_taken", got, 1'b1);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_m_req_irdy"}, m_req_irdy_o, 1'b0);
        chk({nm, "_m_addr"}, m_addr_o, 46'h0);
        chk({nm, "_m_tag"}, m_tag_o, 6'h0);
        chk({nm, "_m_op_size"}, {m_op_o, m_size_o}, 9'h0);
        chk({nm, "_r_ld_irdy"}, r_ld_irdy_o, 3'b000);
        chk({nm, "_r_ld_data"}, r_ld_data_o, 512'h0);
        chk({nm, "_r_ld_misc"}, {r_ld_tag_o, r_ld_acc_fault_o, r_ld_poison_o}, 6'h0);
        chk({nm, "_spur"}, spur_rsp_o, 1'b0);
        chk({nm, "_req_trdy"}, r_req_trdy_o, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order [4] = '{0, 1, 2, 0};
        rst = 1'b1;
        r_addr_i = '0; r_op_i = '0; r_tag_i = '0; r_size_i = '0; r_req_irdy_i = '0;
        r_ld_trdy_i = '0; m_req_trdy_i = 1'b0; m_ld_data_i = '0; m_ld_acc_fault_i = 1'b0;
        m_ld_poison_i = 1'b0; m_ld_tag_i = '0; m_ld_irdy_i = 1'b0;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk_zero_outputs("reset");
        tick(1);

        // Three STORE streams, downstream always ready: grants 0,1,2,0 two cycles apart.
        m_req_trdy_i = 1'b1;
        gq.delete(); gt.delete(); rld_cnt = 0;
        set_req(0, 2'b01, 46'h100, 4'h1, 7'h3);
        set_req(1, 2'b01, 46'h200, 4'h2, 7'h3);
        set_req(2, 2'b11, 46'h300, 4'h3, 7'h3);
        for (int i = 0; i < 20 && gq.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        r_req_irdy_i = '0;
        chk("rr_grant_count", 32'(gq.size()), 32'd4);
        if (gq.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 32'(gq[i]), 32'(exp_order[i]));
            for (int i = 1; i < 4; i++) chk($sformatf("rr_gap%0d", i), 32'(gt[i] - gt[i-1]), 32'd2);
        end
        tick(3);
        chk("rr_no_rsp", 32'(rld_cnt), 32'd0);

        // Single LOAD from req1 and its response.
        set_req(1, 2'b00, 46'h1000, 4'h5, 7'h6);
        wait_accept(1);
        @(negedge clk);
        chk("ld1_m_irdy", m_req_irdy_o, 1'b1);
        chk("ld1_m_tag", m_tag_o, 6'h15);
        chk("ld1_m_addr", m_addr_o, 46'h1000);
        tick(1);
        r_ld_trdy_i = 3'b000;
        send_rsp(6'h15, 512'h2001, 1'b0, 1'b0);
        @(negedge clk);
        chk("ld1_r_irdy", r_ld_irdy_o, 3'b010);
        chk("ld1_r_tag", r_ld_tag_o, 4'h5);
        chk("ld1_r_data", r_ld_data_o, 512'h2001);
        @(posedge clk); #1;
        r_ld_trdy_i = 3'b111;
        tick(1);
        @(negedge clk);
        chk("ld1_delivered", r_ld_irdy_o, 3'b000);
        tick(1);

        // Credit limit: four LOADs outstanding on req0 stall the fifth, a STORE passes it.
        for (int i = 0; i < 4; i++) begin
            set_req(0, 2'b00, 46'h400 + 46'(i * 64), 4'(i), 7'h6);
            wait_accept(0);
        end
        gq.delete();
        set_req(0, 2'b00, 46'h500, 4'h4, 7'h6);
        set_req(2, 2'b01, 46'h600, 4'h7, 7'h6);
        wait_accept(2);
        tick(4);
        chk("credit_only_store", 32'(gq.size()), 32'd1);
        if (gq.size() >= 1) chk("credit_store_idx", 32'(gq[0]), 32'd2);
        send_rsp(6'h00, 512'hA0, 1'b0, 1'b0);
        wait_accept(0);
        tick(2);

        // Spurious responses: index out of range, and requester with nothing owed.
        spur_cnt = 0; rld_cnt = 0;
        send_rsp(6'h30, 512'hDEAD, 1'b0, 1'b0);
        send_rsp(6'h12, 512'hBEEF, 1'b0, 1'b0);
        tick(2);
        chk("spur_pulses", 32'(spur_cnt), 32'd2);
        chk("spur_no_delivery", 32'(rld_cnt), 32'd0);

        // Full buffer stalled by req0 for three cycles, then delivery and refill together.
        r_ld_trdy_i = 3'b000;
        send_rsp(6'h01, 512'hAAAA, 1'b1, 1'b0);
        m_ld_tag_i = 6'h02; m_ld_data_i = 512'hBBBB; m_ld_acc_fault_i = 1'b0;
        m_ld_poison_i = 1'b1; m_ld_irdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_m_trdy%0d", i), m_ld_trdy_o, 1'b0);
            chk($sformatf("stall_data%0d", i), r_ld_data_o, 512'hAAAA);
            chk($sformatf("stall_irdy%0d", i), r_ld_irdy_o, 3'b001);
        end
        @(posedge clk); #1;
        r_ld_trdy_i = 3'b001;
        @(negedge clk);
        chk("release_m_trdy", m_ld_trdy_o, 1'b1);
        @(posedge clk); #1;
        m_ld_irdy_i = 1'b0;
        @(negedge clk);
        chk("refill_irdy", r_ld_irdy_o, 3'b001);
        chk("refill_data", r_ld_data_o, 512'hBBBB);
        chk("refill_tag", r_ld_tag_o, 4'h2);
        chk("refill_poison", r_ld_poison_o, 1'b1);
        tick(2);

        // Reset while BUSY with two LOADs owed to req2 and the pointer at 1.
        m_req_trdy_i = 1'b1;
        set_req(2, 2'b00, 46'h700, 4'h1, 7'h6);
        wait_accept(2);
        set_req(2, 2'b10, 46'h740, 4'h2, 7'h6);
        wait_accept(2);
        tick(2);
        set_req(0, 2'b01, 46'h800, 4'h3, 7'h6);
        wait_accept(0);
        tick(1);
        m_req_trdy_i = 1'b0;
        set_req(1, 2'b01, 46'h900, 4'h4, 7'h6);
        wait_accept(1);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midrst");
        tick(1);
        r_ld_trdy_i = 3'b111; spur_cnt = 0;
        send_rsp(6'h21, 512'h77, 1'b0, 1'b0);
        tick(2);
        chk("midrst_cnt_cleared", 32'(spur_cnt), 32'd1);
        m_req_trdy_i = 1'b1;
        gq.delete();
        set_req(0, 2'b01, 46'hA00, 4'h5, 7'h6);
        set_req(2, 2'b01, 46'hB00, 4'h6, 7'h6);
        wait_accept(0);
        r_req_irdy_i[2] = 1'b0;
        if (gq.size() >= 1) chk("midrst_rr_ptr", 32'(gq[0]), 32'd0);
        else chk("midrst_rr_ptr_seen", 32'(gq.size()), 32'd1);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
